// File: rtl/gray_to_rgb_ser.sv
// gray_to_rgb_ser: expands one gray pixel into 2 or 3 RGB565/666/888 byte beats for the DBI TX FSM
module gray_to_rgb_ser #(
    parameter int GRAY_PXL_W = 8,
    parameter int OUT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            fmt_i,
    input  logic [GRAY_PXL_W-1:0] gray_pxl_dat_i,
    input  logic                  gray_pxl_last_i,
    input  logic                  gray_pxl_vld_i,
    output logic                  gray_pxl_rdy_o,
    output logic [OUT_W-1:0]      rgb_pxl_dat_o,
    output logic                  rgb_pxl_last_o,
    output logic                  rgb_pxl_vld_o,
    input  logic                  rgb_pxl_rdy_i,
    output logic                  busy_o
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    generate
        if (OUT_W != 8) begin : g_bad_out_w
            $error("gray_to_rgb_ser: OUT_W must be 8");
        end
        if (GRAY_PXL_W < 4 || GRAY_PXL_W > 12) begin : g_bad_gray_w
            $error("gray_to_rgb_ser: GRAY_PXL_W must be 4..12");
        end
    endgenerate

    logic [7:0] g8_in;

    // Normalise the incoming gray value to 8 bits: truncate wide inputs, replicate MSBs into narrow ones
    generate
        if (GRAY_PXL_W > 8) begin : g_trunc
            logic unused_lsbs;
            assign g8_in       = gray_pxl_dat_i[GRAY_PXL_W-1 -: 8];
            assign unused_lsbs = ^gray_pxl_dat_i[GRAY_PXL_W-9:0];
        end else if (GRAY_PXL_W == 8) begin : g_pass
            assign g8_in = gray_pxl_dat_i;
        end else begin : g_rep
            assign g8_in = {gray_pxl_dat_i, gray_pxl_dat_i[GRAY_PXL_W-1 -: 8-GRAY_PXL_W]};
        end
    endgenerate

    // Index of the final beat: 3-beat formats are RGB666/RGB888, everything else is 2-beat RGB565
    function automatic logic [1:0] last_beat(input logic [1:0] f);
        return (f == 2'd1 || f == 2'd2) ? 2'd2 : 2'd1;
    endfunction

    // Byte presented on the bus for a given held pixel, format and beat index
    function automatic logic [7:0] beat_val(input logic [7:0] g, input logic [1:0] f, input logic [1:0] b);
        logic [15:0] w;
        w = {g[7:3], g[7:2], g[7:3]};
        return f == 2'd2 ? g : f == 2'd1 ? {g[7:2], 2'b00} : b == 2'd0 ? w[15:8] : w[7:0];
    endfunction

    state_t     state_q, state_d;
    logic [1:0] beat_q, beat_d;
    logic [7:0] g8_q, g8_d;
    logic [1:0] fmt_q, fmt_d;
    logic       last_q, last_d;
    logic [7:0] dat_q, dat_d;
    logic       lst_q, lst_d;
    logic       fin, in_hsk, out_hsk;

    assign fin            = (state_q == SEND) && (beat_q == last_beat(fmt_q));
    assign gray_pxl_rdy_o = (state_q == IDLE) | (fin & rgb_pxl_rdy_i);
    assign in_hsk         = gray_pxl_vld_i & gray_pxl_rdy_o;
    assign out_hsk        = (state_q == SEND) & rgb_pxl_rdy_i;

    // Next-state: accept a pixel (possibly reloading on the final beat), advance the beat, or drain to idle
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        g8_d    = g8_q;
        fmt_d   = fmt_q;
        last_d  = last_q;
        if (in_hsk) begin
            state_d = SEND;
            beat_d  = 2'd0;
            g8_d    = g8_in;
            fmt_d   = fmt_i;
            last_d  = gray_pxl_last_i;
        end else if (out_hsk && fin) begin
            state_d = IDLE;
            beat_d  = 2'd0;
        end else if (out_hsk) begin
            beat_d  = beat_q + 2'd1;
        end
        dat_d = (state_d == SEND) ? beat_val(g8_d, fmt_d, beat_d) : 8'd0;
        lst_d = (state_d == SEND) && last_d && (beat_d == last_beat(fmt_d));
    end

    // Register the serializer state and the outgoing beat so the output interface is fully registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            g8_q    <= 8'd0;
            fmt_q   <= 2'd0;
            last_q  <= 1'b0;
            dat_q   <= 8'd0;
            lst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            g8_q    <= g8_d;
            fmt_q   <= fmt_d;
            last_q  <= last_d;
            dat_q   <= dat_d;
            lst_q   <= lst_d;
        end
    end

    assign rgb_pxl_vld_o  = (state_q == SEND);
    assign rgb_pxl_dat_o  = dat_q;
    assign rgb_pxl_last_o = lst_q;
    assign busy_o         = (state_q == SEND);

endmodule

// File: tb/tb_gray_to_rgb_ser.sv
// tb_gray_to_rgb_ser: scoreboard bench for gray_to_rgb_ser at 8-bit and 4-bit gray widths
module tb_gray_to_rgb_ser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] gf = 2'd0;
    logic       gl = 1'b0;
    logic [7:0] gd = 8'd0;
    logic       gv = 1'b0;
    logic [3:0] g4d = 4'd0;
    logic       g4v = 1'b0;
    logic       rgb_rdy = 1'b1;
    logic       rdy_rand = 1'b0;

    logic       rdy8, last8, vld8, busy8;
    logic [7:0] dat8;
    logic       rdy4, last4, vld4, busy4;
    logic [7:0] dat4;

    int checks = 0;
    int fails = 0;
    logic [8:0] q8[$];
    logic [8:0] q4[$];

    always #5 clk = ~clk;

    gray_to_rgb_ser #(.GRAY_PXL_W(8), .OUT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .fmt_i(gf), .gray_pxl_dat_i(gd), .gray_pxl_last_i(gl),
        .gray_pxl_vld_i(gv), .gray_pxl_rdy_o(rdy8), .rgb_pxl_dat_o(dat8), .rgb_pxl_last_o(last8),
        .rgb_pxl_vld_o(vld8), .rgb_pxl_rdy_i(rgb_rdy), .busy_o(busy8)
    );

    gray_to_rgb_ser #(.GRAY_PXL_W(4), .OUT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .fmt_i(gf), .gray_pxl_dat_i(g4d), .gray_pxl_last_i(gl),
        .gray_pxl_vld_i(g4v), .gray_pxl_rdy_o(rdy4), .rgb_pxl_dat_o(dat4), .rgb_pxl_last_o(last4),
        .rgb_pxl_vld_o(vld4), .rgb_pxl_rdy_i(rgb_rdy), .busy_o(busy4)
    );

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model: list of {last, byte} beats a pixel must produce
    task automatic push_exp(input int g8, input int f, input bit l, input bit sel);
        int w, nb, b;
        w  = ((g8 / 8) * 2048) + ((g8 / 4) * 32) + (g8 / 8);
        nb = (f == 1 || f == 2) ? 3 : 2;
        for (int i = 0; i < nb; i++) begin
            if (f == 2) b = g8;
            else if (f == 1) b = (g8 / 4) * 4;
            else b = (i == 0) ? (w / 256) : (w % 256);
            if (sel) q4.push_back({(l && i == nb - 1), b[7:0]});
            else q8.push_back({(l && i == nb - 1), b[7:0]});
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] g, input logic [1:0] f, input logic l);
        int n = 0;
        gd = g; gf = f; gl = l; gv = 1'b1;
        @(negedge clk);
        while (!rdy8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy8) chk("send8_timeout", 0, 1);
        @(posedge clk);
        push_exp(g, f, l, 1'b0);
        #1 gv = 1'b0;
    endtask

    task automatic send4(input logic [3:0] g, input logic [1:0] f, input logic l);
        int n = 0;
        g4d = g; gf = f; gl = l; g4v = 1'b1;
        @(negedge clk);
        while (!rdy4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy4) chk("send4_timeout", 0, 1);
        @(posedge clk);
        push_exp(g * 17, f, l, 1'b1);
        #1 g4v = 1'b0;
    endtask

    // Output-side ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) rgb_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor for the 8-bit instance: valid must track outstanding beats; front beat must match (and hold while stalled)
    always @(negedge clk) begin
        if (rst_n) begin
            chk("vld8", vld8, q8.size() != 0);
            chk("busy8", busy8, q8.size() != 0);
            if (vld8 && q8.size() != 0) begin
                chk("dat8", dat8, q8[0][7:0]);
                chk("last8", last8, q8[0][8]);
                if (rgb_rdy) void'(q8.pop_front());
            end
        end
    end

    // Monitor for the 4-bit instance
    always @(negedge clk) begin
        if (rst_n) begin
            chk("vld4", vld4, q4.size() != 0);
            if (vld4 && q4.size() != 0) begin
                chk("dat4", dat4, q4[0][7:0]);
                chk("last4", last4, q4[0][8]);
                if (rgb_rdy) void'(q4.pop_front());
            end
        end
    end

    initial begin
        int n;
        @(negedge clk);
        chk("rst_vld", vld8, 0);
        chk("rst_dat", dat8, 0);
        chk("rst_last", last8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_vld4", vld4, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(2);
        send8(8'h80, 2'd0, 1'b0);
        wait_cyc(3);
        send8(8'h81, 2'd1, 1'b0);
        send8(8'h81, 2'd2, 1'b0);
        gf = 2'd0;
        wait_cyc(5);
        send8(8'hFF, 2'd0, 1'b0);
        @(posedge clk);
        #1 rgb_rdy = 1'b0;
        gd = 8'h12; gf = 2'd0; gl = 1'b0; gv = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("in_rdy_stall", rdy8, 0);
        end
        @(posedge clk);
        #1 rgb_rdy = 1'b1;
        send8(8'h12, 2'd0, 1'b0);
        wait_cyc(3);
        send8(8'h3C, 2'd2, 1'b1);
        wait_cyc(4);
        send4(4'hA, 2'd0, 1'b0);
        wait_cyc(3);
        for (int i = 0; i < 12; i++) send4(4'($urandom), 2'($urandom), 1'($urandom));
        wait_cyc(4);
        send8(8'h55, 2'd2, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_vld", vld8, 0);
        chk("midrst_dat", dat8, 0);
        chk("midrst_busy", busy8, 0);
        q8.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        send8(8'h66, 2'd1, 1'b0);
        wait_cyc(4);
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send8(8'($urandom), 2'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                gf = 2'($urandom);
                wait_cyc($urandom_range(1, 3));
            end
        end
        n = 0;
        while ((q8.size() != 0 || q4.size() != 0) && n < 200) begin
            wait_cyc(1);
            n++;
        end
        chk("drain", q8.size() + q4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
